core_memory_subsystem: RTL

Memory responder serving the pipelined core's two master ports: a 16x16 instruction memory and a 16x16 data memory. Before execution it accepts a host word stream that fills instruction memory, then data memory, while holding the core in reset. After loading it enters RUN, releases the core and answers instruction fetches and data loads/stores. It sits beside the core at top level and drives the core's `reset`.

---
 rtl/core_memory_subsystem.sv | 106 ++++++++++
 1 files changed

// File: rtl/core_memory_subsystem.sv
// Instruction/data memory responder: host stream loads imem then dmem under core reset, then serves the core.
// Reads are zero-latency combinational; load_ready is a pure state decode, so the host is paced only by state.
module core_memory_subsystem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              restart,
  output logic              core_reset,
  input  logic [ADDR_W-1:0] address_to_instruction_memory,
  output logic [DATA_W-1:0] data_from_instruction_memory,
  input  logic [ADDR_W-1:0] address_to_main_memory,
  input  logic [DATA_W-1:0] data_to_main_memory,
  input  logic              data_to_main_memory_write_en,
  output logic [DATA_W-1:0] data_from_main_memory,
  output logic [15:0]       dmem_write_count
);

  typedef enum logic [1:0] {IDLE, LOAD_IMEM, LOAD_DMEM, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] word_cnt;
  logic [DATA_W-1:0] imem [DEPTH];
  logic [DATA_W-1:0] dmem [DEPTH];

  logic load_hs;
  logic region_end;
  logic core_wr;

  assign load_hs    = load_valid && load_ready;
  assign region_end = load_hs && ((word_cnt == ADDR_W'(DEPTH - 1)) || load_last);
  assign core_wr    = (state == RUN) && data_to_main_memory_write_en;

  // Outputs are registered alongside the state so they never see load_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      word_cnt         <= '0;
      load_ready       <= 1'b0;
      core_reset       <= 1'b1;
      dmem_write_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state      <= LOAD_IMEM;
          load_ready <= 1'b1;
        end
        LOAD_IMEM: begin
          if (region_end) begin
            state    <= LOAD_DMEM;
            word_cnt <= '0;
          end else if (load_hs) begin
            word_cnt <= word_cnt + ADDR_W'(1);
          end
        end
        LOAD_DMEM: begin
          if (region_end) begin
            state      <= RUN;
            word_cnt   <= '0;
            load_ready <= 1'b0;
            core_reset <= 1'b0;
          end else if (load_hs) begin
            word_cnt <= word_cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (restart) begin
            state      <= LOAD_IMEM;
            word_cnt   <= '0;
            load_ready <= 1'b1;
            core_reset <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (core_wr && (dmem_write_count != 16'hFFFF))
        dmem_write_count <= dmem_write_count + 16'd1;
    end
  end

  // Arrays are deliberately unreset; writes are gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (load_hs && (state == LOAD_IMEM))
      imem[word_cnt] <= load_data;
    if (load_hs && (state == LOAD_DMEM))
      dmem[word_cnt] <= load_data;
    else if (core_wr)
      dmem[address_to_main_memory] <= data_to_main_memory;
  end

  always_comb begin
    data_from_instruction_memory = '0;
    data_from_main_memory        = '0;
    if (state == RUN) begin
      data_from_instruction_memory = imem[address_to_instruction_memory];
      data_from_main_memory        = dmem[address_to_main_memory];
    end
  end

endmodule
